// File: rtl/rob_wide.sv
// Reorder buffer: in-order allocate, multi-port out-of-order completion, up to RETIRE_W
// in-order retires per cycle, and tag-based flush of everything younger than a mispredicted branch.
module rob_wide #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TAG_W    = $clog2(DEPTH),
  parameter int unsigned PREG_W   = 7,
  parameter int unsigned NUM_CPL  = 3,
  parameter int unsigned RETIRE_W = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       write_en_i,
  input  logic [PREG_W-1:0]          pd_new_i,
  input  logic [PREG_W-1:0]          pd_old_i,
  input  logic [31:0]                pc_i,
  input  logic [NUM_CPL-1:0]         cpl_valid_i,
  input  logic [NUM_CPL*TAG_W-1:0]   cpl_tag_i,
  input  logic                       br_mispredict_i,
  input  logic [TAG_W-1:0]           br_mispredict_tag_i,
  output logic [TAG_W-1:0]           ptr_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [TAG_W:0]             count_o,
  output logic [RETIRE_W-1:0]        retire_valid_o,
  output logic [RETIRE_W*PREG_W-1:0] retire_preg_old_o,
  output logic [RETIRE_W*32-1:0]     retire_pc_o,
  output logic                       mispredict_o,
  output logic [TAG_W-1:0]           mispredict_tag_o
);

  localparam int unsigned CW = TAG_W + 1;

  logic [TAG_W-1:0]           head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]              ctr_q, ctr_d;
  logic [DEPTH-1:0]           valid_q, valid_d, done_q, done_d;
  logic [PREG_W-1:0]          pd_old_q [DEPTH];
  logic [31:0]                pc_q     [DEPTH];
  logic [RETIRE_W-1:0]        ret_valid_q, ret_valid_d;
  logic [RETIRE_W*PREG_W-1:0] ret_preg_q, ret_preg_d;
  logic [RETIRE_W*32-1:0]     ret_pc_q, ret_pc_d;
  logic                       mispredict_q, mispredict_d;
  logic [TAG_W-1:0]           mispredict_tag_q, mispredict_tag_d;

  logic                       full, flush_ok, alloc_ok;
  logic [TAG_W-1:0]           br_off;
  logic [CW-1:0]              n_ret;

  // The new mapping is tracked by rename; the ROB only frees the old one.
  logic unused_pd_new;
  assign unused_pd_new = ^pd_new_i;

  always_comb begin
    logic [TAG_W-1:0] idx, off, ct;
    logic             run;
    idx         = '0;
    off         = '0;
    ct          = '0;
    run         = 1'b1;
    valid_d     = valid_q;
    done_d      = done_q;
    ret_valid_d = '0;
    ret_preg_d  = '0;
    ret_pc_d    = '0;
    n_ret       = '0;

    full     = (ctr_q == CW'(DEPTH));
    br_off   = br_mispredict_tag_i - head_q;
    flush_ok = br_mispredict_i && valid_q[br_mispredict_tag_i] && ({1'b0, br_off} < ctr_q);
    alloc_ok = write_en_i && !full && !flush_ok;

    // Retire run from head; on a flush it may not reach past the branch.
    for (int i = 0; i < RETIRE_W; i++) begin
      idx = head_q + TAG_W'(i);
      if (run && (CW'(i) < ctr_q) && done_q[idx] && (!flush_ok || (CW'(i) <= {1'b0, br_off}))) begin
        n_ret = n_ret + CW'(1);
      end else begin
        run = 1'b0;
      end
    end

    for (int k = 0; k < NUM_CPL; k++) begin
      ct  = cpl_tag_i[k*TAG_W +: TAG_W];
      off = ct - head_q;
      if (cpl_valid_i[k] && valid_q[ct] && ({1'b0, off} < ctr_q) &&
          !(flush_ok && (off > br_off))) begin
        done_d[ct] = 1'b1;
      end
    end

    if (flush_ok) begin
      for (int j = 0; j < DEPTH; j++) begin
        off = TAG_W'(j) - head_q;
        if (off > br_off) begin
          valid_d[j] = 1'b0;
          done_d[j]  = 1'b0;
        end
      end
    end

    for (int i = 0; i < RETIRE_W; i++) begin
      idx = head_q + TAG_W'(i);
      if (CW'(i) < n_ret) begin
        ret_valid_d[i]                  = 1'b1;
        ret_preg_d[i*PREG_W +: PREG_W]  = pd_old_q[idx];
        ret_pc_d[i*32 +: 32]            = pc_q[idx];
        valid_d[idx]                    = 1'b0;
        done_d[idx]                     = 1'b0;
      end
    end

    if (alloc_ok) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
    end

    head_d = head_q + n_ret[TAG_W-1:0];
    if (flush_ok) begin
      tail_d = br_mispredict_tag_i + TAG_W'(1);
      ctr_d  = {1'b0, br_off} + CW'(1) - n_ret;
    end else begin
      tail_d = tail_q + TAG_W'(alloc_ok);
      ctr_d  = ctr_q + CW'(alloc_ok) - n_ret;
    end

    mispredict_d     = flush_ok;
    mispredict_tag_d = flush_ok ? br_mispredict_tag_i : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q           <= '0;
      tail_q           <= '0;
      ctr_q            <= '0;
      valid_q          <= '0;
      done_q           <= '0;
      ret_valid_q      <= '0;
      ret_preg_q       <= '0;
      ret_pc_q         <= '0;
      mispredict_q     <= 1'b0;
      mispredict_tag_q <= '0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      ctr_q            <= ctr_d;
      valid_q          <= valid_d;
      done_q           <= done_d;
      ret_valid_q      <= ret_valid_d;
      ret_preg_q       <= ret_preg_d;
      ret_pc_q         <= ret_pc_d;
      mispredict_q     <= mispredict_d;
      mispredict_tag_q <= mispredict_tag_d;
    end
  end

  // Payload is only read for live entries, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (alloc_ok) begin
      pd_old_q[tail_q] <= pd_old_i;
      pc_q[tail_q]     <= pc_i;
    end
  end

  assign ptr_o             = tail_q;
  assign full_o            = full;
  assign empty_o           = (ctr_q == '0);
  assign count_o           = ctr_q;
  assign retire_valid_o    = ret_valid_q;
  assign retire_preg_old_o = ret_preg_q;
  assign retire_pc_o       = ret_pc_q;
  assign mispredict_o      = mispredict_q;
  assign mispredict_tag_o  = mispredict_tag_q;

endmodule

// File: tb/tb_rob_wide.sv
// Randomised and directed bench for rob_wide against a program-order queue model.
module tb_rob_wide;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [6:0]  pdn = '0, pdo = '0;
  logic [31:0] pc = '0;
  logic [2:0]  cv = '0;
  logic [11:0] ct = '0;
  logic        bm = 1'b0;
  logic [3:0]  bt = '0;

  logic [3:0]  ptr;
  logic        full, empty;
  logic [4:0]  count;
  logic [1:0]  rv;
  logic [13:0] rpreg;
  logic [63:0] rpc;
  logic        mis;
  logic [3:0]  mtag;

  rob_wide dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .write_en_i          (we),
    .pd_new_i            (pdn),
    .pd_old_i            (pdo),
    .pc_i                (pc),
    .cpl_valid_i         (cv),
    .cpl_tag_i           (ct),
    .br_mispredict_i     (bm),
    .br_mispredict_tag_i (bt),
    .ptr_o               (ptr),
    .full_o              (full),
    .empty_o             (empty),
    .count_o             (count),
    .retire_valid_o      (rv),
    .retire_preg_old_o   (rpreg),
    .retire_pc_o         (rpc),
    .mispredict_o        (mis),
    .mispredict_tag_o    (mtag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [6:0]  pd_old;
    logic [31:0] pc;
    bit          done;
  } ent_t;

  ent_t        q[$];
  int          m_tail = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input bit w, input logic [2:0] v, input logic [11:0] t,
                       input bit m, input logic [3:0] mt);
    int          pos, n, sz0, tg;
    bit          flush;
    logic [1:0]  e_rv;
    logic [13:0] e_preg, mp;
    logic [63:0] e_pc, mc;
    ent_t        e;
    we = w; pdo = 7'($urandom); pdn = 7'($urandom); pc = $urandom;
    cv = v; ct = t; bm = m; bt = mt;

    sz0 = q.size();
    pos = -1;
    foreach (q[i]) if (q[i].tag == int'(mt)) pos = i;
    flush = m && (pos >= 0);
    n = 0;
    while (n < 2 && n < q.size() && q[n].done && (!flush || n <= pos)) n++;
    e_rv = 2'((1 << n) - 1);
    e_preg = '0; e_pc = '0;
    for (int i = 0; i < n; i++) begin
      e_preg[i*7 +: 7] = q[i].pd_old;
      e_pc[i*32 +: 32] = q[i].pc;
    end
    for (int k = 0; k < 3; k++) begin
      if (v[k]) begin
        tg = int'(t[k*4 +: 4]);
        foreach (q[i]) if (q[i].tag == tg && (!flush || i <= pos)) q[i].done = 1'b1;
      end
    end
    if (flush) while (q.size() > pos + 1) void'(q.pop_back());
    repeat (n) void'(q.pop_front());
    if (flush) begin
      m_tail = (int'(mt) + 1) % 16;
    end else if (w && sz0 < 16) begin
      e.tag = m_tail; e.pd_old = pdo; e.pc = pc; e.done = 1'b0;
      q.push_back(e);
      m_tail = (m_tail + 1) % 16;
    end

    @(posedge clk);
    #1;
    mp = '0; mc = '0;
    for (int i = 0; i < 2; i++) if (e_rv[i]) begin
      mp[i*7 +: 7] = '1;
      mc[i*32 +: 32] = '1;
    end
    check("ptr", 64'(ptr), 64'(m_tail));
    check("count", 64'(count), 64'(q.size()));
    check("full", 64'(full), 64'(q.size() == 16));
    check("empty", 64'(empty), 64'(q.size() == 0));
    check("retire_valid", 64'(rv), 64'(e_rv));
    check("retire_preg", 64'(rpreg & mp), 64'(e_preg));
    check("retire_pc", rpc & mc, e_pc);
    check("mispredict", 64'(mis), 64'(flush));
    if (flush) check("mispredict_tag", 64'(mtag), 64'(mt));
  endtask

  task automatic idle();
    cycle(1'b0, 3'b000, 12'h000, 1'b0, 4'd0);
  endtask

  task automatic alloc(input int cnt);
    repeat (cnt) cycle(1'b1, 3'b000, 12'h000, 1'b0, 4'd0);
  endtask

  // Asserts reset away from a clock edge; outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_ptr"}, 64'(ptr), 64'd0);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_full"}, 64'(full), 64'd0);
    check({tag, "_empty"}, 64'(empty), 64'd1);
    check({tag, "_rv"}, 64'(rv), 64'd0);
    check({tag, "_preg"}, 64'(rpreg), 64'd0);
    check({tag, "_pc"}, rpc, 64'd0);
    check({tag, "_mis"}, 64'(mis), 64'd0);
    check({tag, "_mtag"}, 64'(mtag), 64'd0);
    we = 1'b0; cv = '0; bm = 1'b0; ct = '0; bt = '0;
    q.delete();
    m_tail = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] pick_tag();
    if (q.size() > 0 && ($urandom % 4) != 0) return 4'(q[$urandom % q.size()].tag);
    return 4'($urandom);
  endfunction

  initial begin
    logic [11:0] t;
    do_reset("rst0");

    // Out-of-order completion of the two oldest; the third stays pending.
    alloc(3);
    cycle(1'b0, 3'b101, {4'd0, 4'd0, 4'd1}, 1'b0, 4'd0);
    idle();
    check("t1_rv", 64'(rv), 64'd3);
    check("t1_count", 64'(count), 64'd1);
    cycle(1'b0, 3'b001, {4'd0, 4'd0, 4'd2}, 1'b0, 4'd0);
    idle();

    // Four completions over two cycles drain two per cycle.
    do_reset("rst2");
    alloc(4);
    cycle(1'b0, 3'b111, {4'd2, 4'd1, 4'd0}, 1'b0, 4'd0);
    cycle(1'b0, 3'b001, {4'd0, 4'd0, 4'd3}, 1'b0, 4'd0);
    idle();
    idle();
    check("t2_empty", 64'(empty), 64'd1);

    // Flush drops the completed younger entry; its slot reallocates not-done.
    do_reset("rst3");
    alloc(4);
    cycle(1'b0, 3'b001, {4'd0, 4'd0, 4'd3}, 1'b0, 4'd0);
    cycle(1'b0, 3'b000, 12'h000, 1'b1, 4'd2);
    check("t3_ptr", 64'(ptr), 64'd3);
    check("t3_count", 64'(count), 64'd3);
    check("t3_mis", 64'(mis), 64'd1);
    check("t3_mtag", 64'(mtag), 64'd2);
    alloc(1);
    cycle(1'b0, 3'b111, {4'd2, 4'd1, 4'd0}, 1'b0, 4'd0);
    idle();
    idle();
    check("t3_stale_done", 64'(count), 64'd1);

    // Full: extra write dropped, retire frees space, wrapped alloc reuses old head tag.
    do_reset("rst4");
    alloc(16);
    check("t4_full", 64'(full), 64'd1);
    alloc(1);
    check("t4_drop", 64'(count), 64'd16);
    cycle(1'b0, 3'b011, {4'd0, 4'd1, 4'd0}, 1'b0, 4'd0);
    idle();
    check("t4_count", 64'(count), 64'd14);
    check("t4_ptr", 64'(ptr), 64'd0);
    alloc(1);
    check("t4_wrap", 64'(ptr), 64'd1);

    // Mispredict at head while head and head+1 are done: only the branch retires.
    do_reset("rst5");
    alloc(4);
    cycle(1'b0, 3'b011, {4'd0, 4'd1, 4'd0}, 1'b0, 4'd0);
    cycle(1'b0, 3'b000, 12'h000, 1'b1, 4'd0);
    check("t5_rv", 64'(rv), 64'd1);
    check("t5_count", 64'(count), 64'd0);
    check("t5_ptr", 64'(ptr), 64'd1);

    // Reset in the middle of a pending flush.
    do_reset("rst6a");
    alloc(5);
    bm = 1'b1; bt = 4'd2;
    @(negedge clk);
    do_reset("rst6");

    for (int c = 0; c < 1500; c++) begin
      t = {pick_tag(), pick_tag(), pick_tag()};
      if (($urandom % 400) == 0) begin
        @(negedge clk);
        do_reset("rstr");
      end
      cycle(($urandom % 10) < 7, 3'($urandom), t, ($urandom % 20) == 0, pick_tag());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not terminate");
  end

endmodule
